waves_nios_dac_stream: RTL and testbench
========================================

Name: waves_nios_dac_stream

Overview:
- Parametrised successor to the single-register Nios DAC output port.
- Avalon-MM slave with a write FIFO of DAC samples, drained at a programmable sample rate (clock divider) onto a registered parallel output.
- Adds underflow/overflow status and a low-water interrupt, so the Nios core can stream waveforms without per-sample timing.
- Sits between the Nios data master and the external DAC pins.

Parameters:
- DATA_WIDTH, 16, sample/out_port width (1..32).
- FIFO_AW, 6, FIFO address bits; depth = 2**FIFO_AW (1..15).
- DIV_WIDTH, 16, sample-period divider register width (1..32).
- LOW_WATER, 16, IRQ asserts when fill level <= this value (0..2**FIFO_AW).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- read_n  in  1  active-low read strobe (no side effects; readdata is valid whenever address is stable).
- writedata  in  32  write data.
- readdata  out  32  read data; combinational from address, zero read latency.
- out_port  out  DATA_WIDTH  registered sample to the DAC.
- irq  out  1  level interrupt.

Behaviour:
- Interface: one clock `clk`; reset `reset` is asynchronous and active-high. All state is cleared on assertion, regardless of clk.
- Write qualifier: wr = chipselect & ~write_n.

Register map (unused bits read 0):
- addr0 DATA
  - Write: push writedata[DATA_WIDTH-1:0] into the FIFO. If full: word dropped, overflow flag set.
  - Read: zero-extended out_port.
- addr1 CTRL
  - bit0 enable, bit2 irq_en: read/write.
  - bit1 clear: write-1 flushes the FIFO (level=0) in that cycle. Self-clearing, reads 0, out_port unchanged.
- addr2 DIV: sample period minus 1, DIV_WIDTH bits, read/write.
- addr3 STATUS
  - bit0 empty, bit1 full.
  - bit2 underflow (sticky), bit3 overflow (sticky). Write-1-to-clear on bits 2/3.
  - bits[16+FIFO_AW:16] level (0..depth).

Reset values:
- out_port=0, enable=0, irq_en=0, DIV=0.
- FIFO empty (level=0), sticky flags=0, cnt=0, irq=0.

Tick generator:
- enable=0: cnt <= DIV; no ticks.
- enable=1: if cnt==0 then tick and cnt <= DIV, else cnt <= cnt-1.
- First tick occurs DIV+1 cycles after the edge that sets enable. Sample period is DIV+1 cycles; DIV=0 gives a tick every cycle.
- A DIV write while running takes effect at the next reload.

Tick action:
- FIFO non-empty: on the tick edge, out_port <= head and the FIFO pops. out_port changes the cycle after cnt==0 is observed.
- FIFO empty: out_port holds its last value and underflow is set.

FIFO and flag rules:
- Simultaneous push and pop: both happen; level unchanged, including when full (push accepted because a pop frees a slot). No overflow in that case.
- Push to empty FIFO with a tick in the same cycle: no pop (FIFO is not bypassed), underflow set, word stored.
- Clear coinciding with push or pop: clear wins; FIFO empty, pushed word discarded, out_port unchanged.
- Status W1C coinciding with a new set event: set wins.
- Read/write pointers wrap modulo depth; full and empty are derived from a FIFO_AW+1-bit level counter.
- irq (registered): irq <= irq_en & (underflow | (level <= LOW_WATER)). One-cycle latency.

Test Plan:
- Reset mid-stream: assert reset with level=5 and out_port=0x1234 -> out_port=0, level=0, irq=0, CTRL/DIV/STATUS read 0 (STATUS bit0=1) immediately, without a clk edge.
- Rate: DIV=3; push 0x0001, 0x0002, 0x0003; set enable -> out_port becomes 1, 2, 3 at 4-cycle spacing, first change 4 cycles after enable. Then underflow sets on the next tick and out_port holds 3.
- Full/overflow: depth 64, enable=0, push 65 words -> level=64, full=1, overflow=1, first 64 words emerge in order; W1C 0x8 clears overflow only.
- Simultaneous: full FIFO, DIV=0, enable=1, push on a tick cycle -> level stays 64, overflow stays 0, pushed word appears 64 ticks later.
- Clear: level=10, write CTRL clear=1 with enable=1 -> level=0, empty=1, out_port unchanged, underflow set at the next tick.
- IRQ: LOW_WATER=16, irq_en=1, level 17 -> irq=0; one tick pops -> irq=1 one cycle after level reaches 16; irq_en=0 -> irq=0 next cycle.

Source files
------------

// File: rtl/waves_nios_dac_stream_if.sv
// Avalon-MM slave bus plus DAC-side outputs for the streaming DAC port.
// The master modport is the Nios/bench side; the slave modport is the DAC block.
interface waves_nios_dac_stream_if #(
   parameter int DATA_WIDTH = 16
);
   logic [1:0]            address;
   logic                  chipselect;
   logic                  write_n;
   logic                  read_n;
   logic [31:0]           writedata;
   logic [31:0]           readdata;
   logic [DATA_WIDTH-1:0] out_port;
   logic                  irq;

   modport master (
      output address, chipselect, write_n, read_n, writedata,
      input  readdata, out_port, irq
   );

   modport slave (
      input  address, chipselect, write_n, read_n, writedata,
      output readdata, out_port, irq
   );
endinterface

// File: rtl/waves_nios_dac_stream.sv
// Streaming DAC port: Avalon-MM write FIFO drained at a programmable sample rate
// onto a registered parallel output, with sticky under/overflow flags and a low-water IRQ.
module waves_nios_dac_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_AW    = 6,
   parameter int DIV_WIDTH  = 16,
   parameter int LOW_WATER  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   waves_nios_dac_stream_if.slave bus
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0]   LVL_DEPTH = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0]   LVL_LOW   = (FIFO_AW + 1)'(LOW_WATER);
   localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = (FIFO_AW)'(1);
   localparam logic [DIV_WIDTH-1:0] CNT_ONE = (DIV_WIDTH)'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [FIFO_AW-1:0]    r_wr_ptr;
   logic [FIFO_AW-1:0]    r_rd_ptr;
   logic [FIFO_AW:0]      r_level;
   logic [DIV_WIDTH-1:0]  r_div;
   logic [DIV_WIDTH-1:0]  r_cnt;
   logic [DATA_WIDTH-1:0] r_out;
   logic                  r_enable;
   logic                  r_irq_en;
   logic                  r_underflow;
   logic                  r_overflow;
   logic                  r_irq;

   logic        w_wr;
   logic        w_push_req;
   logic        w_clear;
   logic        w_ctrl_wr;
   logic        w_div_wr;
   logic        w_status_wr;
   logic        w_empty;
   logic        w_full;
   logic        w_tick;
   logic        w_pop;
   logic        w_push;
   logic        w_underflow_set;
   logic        w_overflow_set;
   logic [31:0] w_readdata;
   logic        w_unused;

   assign w_wr        = bus.chipselect & ~bus.write_n;
   assign w_push_req  = w_wr && (bus.address == 2'd0);
   assign w_ctrl_wr   = w_wr && (bus.address == 2'd1);
   assign w_div_wr    = w_wr && (bus.address == 2'd2);
   assign w_status_wr = w_wr && (bus.address == 2'd3);
   assign w_clear     = w_ctrl_wr & bus.writedata[1];

   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == LVL_DEPTH);
   assign w_tick  = r_enable && (r_cnt == '0);

   // Flush beats both ends; a pop frees the slot a same-cycle push needs when full.
   assign w_pop           = w_tick & ~w_empty & ~w_clear;
   assign w_push          = w_push_req & ~w_clear & (~w_full | w_pop);
   assign w_underflow_set = w_tick & w_empty;
   assign w_overflow_set  = w_push_req & ~w_clear & w_full & ~w_pop;

   assign w_unused = &{1'b0, bus.read_n, bus.writedata};

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.writedata[DATA_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_div       <= '0;
         r_cnt       <= '0;
         r_out       <= '0;
         r_enable    <= 1'b0;
         r_irq_en    <= 1'b0;
         r_underflow <= 1'b0;
         r_overflow  <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         // Reload from DIV while idle or on a tick, so a new DIV lands at the next reload.
         if (!r_enable || (r_cnt == '0)) begin
            r_cnt <= r_div;
         end else begin
            r_cnt <= r_cnt - CNT_ONE;
         end

         if (w_pop) begin
            r_out <= r_mem[r_rd_ptr];
         end

         if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_push && !w_pop) begin
               r_level <= r_level + LVL_ONE;
            end else if (!w_push && w_pop) begin
               r_level <= r_level - LVL_ONE;
            end
         end

         if (w_ctrl_wr) begin
            r_enable <= bus.writedata[0];
            r_irq_en <= bus.writedata[2];
         end
         if (w_div_wr) begin
            r_div <= bus.writedata[DIV_WIDTH-1:0];
         end

         if (w_underflow_set) begin
            r_underflow <= 1'b1;
         end else if (w_status_wr && bus.writedata[2]) begin
            r_underflow <= 1'b0;
         end
         if (w_overflow_set) begin
            r_overflow <= 1'b1;
         end else if (w_status_wr && bus.writedata[3]) begin
            r_overflow <= 1'b0;
         end

         r_irq <= r_irq_en & (r_underflow | (r_level <= LVL_LOW));
      end
   end

   always_comb begin
      w_readdata = '0;
      case (bus.address)
         2'd0: w_readdata[DATA_WIDTH-1:0] = r_out;
         2'd1: begin
            w_readdata[0] = r_enable;
            w_readdata[2] = r_irq_en;
         end
         2'd2: w_readdata[DIV_WIDTH-1:0] = r_div;
         default: begin
            w_readdata[0]                 = w_empty;
            w_readdata[1]                 = w_full;
            w_readdata[2]                 = r_underflow;
            w_readdata[3]                 = r_overflow;
            w_readdata[16+FIFO_AW:16]     = r_level;
         end
      endcase
   end

   assign bus.readdata = w_readdata;
   assign bus.out_port = r_out;
   assign bus.irq      = r_irq;
endmodule

// File: tb/tb_waves_nios_dac_stream.sv
// Randomised + directed bench: a queue-based reference model predicts the post-edge
// state each cycle; a separate monitor pops predictions and compares the DUT outputs.
`timescale 1ns/1ps
module tb_waves_nios_dac_stream;
   localparam int DW    = 16;
   localparam int AW    = 6;
   localparam int DVW   = 16;
   localparam int LW    = 16;
   localparam int DEPTH = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   waves_nios_dac_stream_if #(.DATA_WIDTH(DW)) bus ();

   waves_nios_dac_stream #(
      .DATA_WIDTH(DW),
      .FIFO_AW   (AW),
      .DIV_WIDTH (DVW),
      .LOW_WATER (LW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      int unsigned out;
      bit          irq;
      int          level;
      bit          en;
      bit          irqen;
      int unsigned div;
      bit          unf;
      bit          ovf;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   mon_en   = 1'b0;

   // Reference model state
   int unsigned m_fifo[$];
   int unsigned m_out, m_div, m_cnt;
   bit          m_en, m_irqen, m_unf, m_ovf, m_irq;

   function automatic void check(string name, longint unsigned act, longint unsigned exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endfunction

   function automatic void model_reset();
      m_fifo.delete();
      m_out = 0; m_div = 0; m_cnt = 0;
      m_en = 0; m_irqen = 0; m_unf = 0; m_ovf = 0; m_irq = 0;
   endfunction

   function automatic void model_step(logic [1:0] a, logic cs, logic wn, int unsigned wd);
      bit wr, push_req, clr, tick, unf_set, ovf_set, new_irq;
      wr       = cs && !wn;
      push_req = wr && (a == 2'd0);
      clr      = wr && (a == 2'd1) && wd[1];
      tick     = m_en && (m_cnt == 0);
      new_irq  = m_irqen && (m_unf || (m_fifo.size() <= LW));
      unf_set  = tick && (m_fifo.size() == 0);
      ovf_set  = 1'b0;
      if (clr) begin
         m_fifo.delete();
      end else begin
         if (tick && m_fifo.size() > 0) m_out = m_fifo.pop_front();
         if (push_req) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(wd & 32'hFFFF);
            else ovf_set = 1'b1;
         end
      end
      m_cnt = (!m_en || m_cnt == 0) ? m_div : m_cnt - 1;
      if (wr && a == 2'd1) begin
         m_en    = wd[0];
         m_irqen = wd[2];
      end
      if (wr && a == 2'd2) m_div = wd & 32'hFFFF;
      if (unf_set) m_unf = 1'b1;
      else if (wr && a == 2'd3 && wd[2]) m_unf = 1'b0;
      if (ovf_set) m_ovf = 1'b1;
      else if (wr && a == 2'd3 && wd[3]) m_ovf = 1'b0;
      m_irq = new_irq;
   endfunction

   function automatic exp_t snap();
      exp_t e;
      e.out = m_out; e.irq = m_irq; e.level = m_fifo.size();
      e.en = m_en; e.irqen = m_irqen; e.div = m_div; e.unf = m_unf; e.ovf = m_ovf;
      return e;
   endfunction

   function automatic int unsigned exp_rd(exp_t e, logic [1:0] a);
      case (a)
         2'd0:    return e.out;
         2'd1:    return int'(e.en) | (int'(e.irqen) << 2);
         2'd2:    return e.div;
         default: return int'(e.level == 0) | (int'(e.level == DEPTH) << 1) |
                         (int'(e.unf) << 2) | (int'(e.ovf) << 3) | (e.level << 16);
      endcase
   endfunction

   // Monitor: one prediction per clock edge, compared at the following falling edge.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("out_port", bus.out_port, e.out);
            check("irq", bus.irq, e.irq);
            check($sformatf("readdata_a%0d", bus.address), bus.readdata, exp_rd(e, bus.address));
         end
      end
   end

   task automatic bus_cycle(input logic [1:0] a, input logic cs, input logic wn, input int unsigned wd);
      bus.address    = a;
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.read_n     = 1'($urandom_range(0, 1));
      bus.writedata  = wd;
      @(posedge clk);
      model_step(a, cs, wn, wd);
      sb_q.push_back(snap());
      #1;
   endtask

   task automatic write_reg(input logic [1:0] a, input int unsigned wd);
      bus_cycle(a, 1'b1, 1'b0, wd);
   endtask

   task automatic idle(input int n);
      int unsigned r;
      for (int i = 0; i < n; i++) begin
         r = $urandom;
         bus_cycle(2'(r[3:2]), r[0], r[0] ? 1'b1 : r[1], $urandom);
      end
   endtask

   task automatic reset_test();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      @(negedge clk);
      #1;
      mon_en = 1'b0;
      reset  = 1'b1;
      #0.5;
      check("rst_out_port", bus.out_port, 0);
      check("rst_irq", bus.irq, 0);
      for (int a = 0; a < 4; a++) begin
         bus.address = a[1:0];
         #0.5;
         check($sformatf("rst_readdata_a%0d", a), bus.readdata, (a == 3) ? 1 : 0);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin : driver
      int unsigned r, v;
      bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
      bus.read_n = 1'b1; bus.writedata = 32'd0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset  = 1'b0;
      mon_en = 1'b1;

      // Rate: DIV=3, three samples, then underflow while holding the last value
      write_reg(2, 3);
      write_reg(0, 32'h0001);
      write_reg(0, 32'h0002);
      write_reg(0, 32'h0003);
      write_reg(1, 32'h1);
      idle(20);

      // Overflow with enable off, W1C of overflow only, then push on a tick while full
      write_reg(1, 32'h2);
      write_reg(3, 32'hC);
      write_reg(2, 0);
      for (int i = 0; i < 65; i++) write_reg(0, $urandom);
      idle(3);
      write_reg(3, 32'h8);
      idle(2);
      write_reg(1, 32'h1);
      write_reg(0, 32'hBEEF);
      idle(70);

      // Clear with enable set while 10 words are queued
      write_reg(1, 32'h2);
      write_reg(2, 2);
      for (int i = 0; i < 10; i++) write_reg(0, $urandom);
      write_reg(1, 32'h3);
      idle(10);

      // Low-water IRQ crossing, then irq_en off
      write_reg(1, 32'h2);
      write_reg(3, 32'hC);
      write_reg(2, 5);
      for (int i = 0; i < 17; i++) write_reg(0, $urandom);
      idle(2);
      write_reg(1, 32'h5);
      idle(10);
      write_reg(1, 32'h1);
      idle(3);

      // Reset mid-stream with level=5 and out_port=0x1234
      write_reg(1, 32'h2);
      write_reg(2, 0);
      write_reg(0, 32'h1234);
      write_reg(1, 32'h1);
      idle(3);
      write_reg(1, 32'h0);
      for (int i = 0; i < 5; i++) write_reg(0, $urandom);
      idle(2);
      reset_test();

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 45) begin
            write_reg(0, $urandom);
         end else if (r < 49) begin
            v    = $urandom;
            v[1] = ($urandom_range(0, 9) == 0);
            v[0] = ($urandom_range(0, 4) != 0);
            write_reg(1, v);
         end else if (r < 52) begin
            v = $urandom;
            v[15:3] = '0;
            write_reg(2, v);
         end else if (r < 56) begin
            write_reg(3, $urandom);
         end else begin
            idle(1);
         end
      end
      idle(5);

      @(negedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
